cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 156 +++++++++++++++
 tb/tb_cache_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, write-allocate cache controller.
// One 32-bit word per line. Tags and valid bits are kept here, and the data
// words live in an external array. That array and main memory both present
// registered read data on the falling edge after the address is driven.
//
//  state  | meaning
//  IDLE   | waiting for cpu_req; latches the request on acceptance
//  LOOKUP | cache_addr driven, tag compare, statistics update
//  MEM_RD | read miss: fetch the word from main memory
//  FILL   | write the fetched word into the cache line, set tag/valid
//  WRITE  | write-through to memory and the cache line together
//  DONE   | one-cycle cpu_ready pulse
module cache_controller #(
    parameter int index      = 3,
    parameter int memorybits = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [memorybits-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic [index-1:0]      cache_addr,
    output logic [31:0]           cache_wdata,
    output logic                  cache_we,
    input  logic [31:0]           cache_rdata,
    output logic [memorybits-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    input  logic [31:0]           mem_rdata,
    output logic [7:0]            hit_count,
    output logic [7:0]            miss_count
);

    localparam int TAGW  = memorybits - index;
    localparam int LINES = 1 << index;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] MEM_RD = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]            state;
    logic                  req_we;
    logic [memorybits-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic [31:0]           fill_data;
    logic [TAGW-1:0]       tag_store [0:LINES-1];
    logic [LINES-1:0]      valid;

    logic [index-1:0]      idx;
    logic [TAGW-1:0]       tag;
    logic                  hit;

    assign idx = req_addr[index-1:0];
    assign tag = req_addr[memorybits-1:index];
    assign hit = valid[idx] && (tag_store[idx] == tag);

    // Main FSM with valid bits, statistics and returned read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            valid      <= '0;
            hit_count  <= 8'd0;
            miss_count <= 8'd0;
            cpu_rdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) state <= LOOKUP;
                end
                LOOKUP: begin
                    if (hit) begin
                        if (hit_count != 8'hFF) hit_count <= hit_count + 8'd1;
                    end else begin
                        if (miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
                    end
                    if (req_we) begin
                        state <= WRITE;
                    end else if (hit) begin
                        cpu_rdata <= cache_rdata;
                        state     <= DONE;
                    end else begin
                        state <= MEM_RD;
                    end
                end
                MEM_RD: begin
                    cpu_rdata <= mem_rdata;
                    state     <= FILL;
                end
                FILL: begin
                    valid[idx] <= 1'b1;
                    state      <= DONE;
                end
                WRITE: begin
                    valid[idx] <= 1'b1;
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Request latch and fill buffer; contents only matter once a request is in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
        end
        if (state == MEM_RD) fill_data <= mem_rdata;
    end

    // Tag store is deliberately not cleared by reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (!reset && (state == FILL || state == WRITE)) tag_store[idx] <= tag;
    end

    // Array/memory strobes and buses; everything forced low while reset is high.
    always_comb begin
        cache_addr  = '0;
        cache_wdata = 32'd0;
        cache_we    = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 32'd0;
        mem_we      = 1'b0;
        cpu_ready   = 1'b0;
        if (!reset) begin
            case (state)
                LOOKUP: cache_addr = idx;
                MEM_RD: mem_addr = req_addr;
                FILL: begin
                    cache_addr  = idx;
                    cache_wdata = fill_data;
                    cache_we    = 1'b1;
                end
                WRITE: begin
                    cache_addr  = idx;
                    cache_wdata = req_wdata;
                    cache_we    = 1'b1;
                    mem_addr    = req_addr;
                    mem_wdata   = req_wdata;
                    mem_we      = 1'b1;
                end
                DONE:    cpu_ready = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: stimulus pushes expected responses,
// a monitor pops and checks them whenever cpu_ready pulses.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic [4:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic [2:0]  cache_addr;
    logic [31:0] cache_wdata;
    logic        cache_we;
    logic [31:0] cache_rdata;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    cache_controller #(.index(3), .memorybits(5)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .cache_addr(cache_addr), .cache_wdata(cache_wdata), .cache_we(cache_we),
        .cache_rdata(cache_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // External data array and main memory: falling-edge registered reads.
    logic [31:0] carr [0:7];
    logic [31:0] mem  [0:31];
    always @(posedge clk) begin
        if (cache_we) carr[cache_addr] <= cache_wdata;
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    always @(negedge clk) begin
        cache_rdata <= carr[cache_addr];
        mem_rdata   <= mem[mem_addr];
    end

    // kind: 0 = read hit, 1 = read miss, 2 = write
    typedef struct {
        int          kind;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ready_seen = 0;

    bit   busy = 0;
    bit   skip = 0;
    bit   strobe_ok = 1;
    int   lat = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Acceptance model: a request is taken in IDLE only, never in DONE.
    always @(posedge clk) begin
        if (reset) begin
            busy = 0;
            skip = 0;
        end else if (skip) begin
            skip = 0;
        end else if (!busy && cpu_req) begin
            busy = 1;
            lat = 0;
            strobe_ok = 1;
        end
    end

    // Monitor: latency, strobes and read data against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        logic ec, em;
        if (busy) begin
            lat++;
            if (q.size() > 0) begin
                ec = (q[0].kind == 1 && lat == 3) || (q[0].kind == 2 && lat == 2);
                em = (q[0].kind == 2 && lat == 2);
                if (cache_we !== ec || mem_we !== em) strobe_ok = 0;
            end
            if (cpu_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got cpu_ready=1 expected no completion");
                end else begin
                    e = q.pop_front();
                    check32("latency", lat, e.lat);
                    check32("cpu_rdata", cpu_rdata, e.rdata);
                    check32("strobes", {31'd0, strobe_ok}, 32'd1);
                end
                busy = 0;
                skip = 1;
                ready_seen++;
            end else if (lat > 8) begin
                n_checks++;
                n_fail++;
                $display("FAIL timeout_ready: got no cpu_ready after %0d cycles expected completion", lat);
                busy = 0;
            end
        end else begin
            n_checks++;
            if (cpu_ready || cache_we || mem_we) begin
                n_fail++;
                $display("FAIL idle_activity: got ready=%b cache_we=%b mem_we=%b expected 0 0 0",
                         cpu_ready, cache_we, mem_we);
            end
        end
    end

    task automatic wait_ready(input int target);
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (ready_seen >= target) done = 1;
            else @(negedge clk);
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: got %0d completions expected %0d", ready_seen, target);
        end
    endtask

    task automatic issue(input logic we, input logic [4:0] a, input logic [31:0] d,
                         input int kind, input logic [31:0] exp_rd, input int exp_lat);
        exp_t e;
        int start;
        @(negedge clk);
        e.kind = kind; e.rdata = exp_rd; e.lat = exp_lat;
        q.push_back(e);
        start = ready_seen;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_req = 1'b0;
        wait_ready(start + 1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int start;
        for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
        for (int i = 0; i < 8; i++) carr[i] = 32'd0;
        mem[5'h0D] = 32'hCAFE_0001;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 5'd0; cpu_wdata = 32'd0;
        repeat (3) @(negedge clk);

        // Reset state (reset still high here, outputs gated)
        check32("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
        check32("rst_cpu_rdata", cpu_rdata, 32'd0);
        check32("rst_hit_count", {24'd0, hit_count}, 32'd0);
        check32("rst_miss_count", {24'd0, miss_count}, 32'd0);
        check32("rst_cache_addr", {29'd0, cache_addr}, 32'd0);
        check32("rst_mem_addr", {27'd0, mem_addr}, 32'd0);
        reset = 1'b0;

        // Cold read miss, then hit on the same word
        issue(1'b0, 5'h0D, 32'd0, 1, 32'hCAFE_0001, 4);
        check32("miss_count_1", {24'd0, miss_count}, 32'd1);
        issue(1'b0, 5'h0D, 32'd0, 0, 32'hCAFE_0001, 2);
        check32("hit_count_1", {24'd0, hit_count}, 32'd1);

        // Conflicting write (index 5, tag 2 evicts tag 1); cpu_rdata unchanged
        issue(1'b1, 5'h15, 32'h1234_5678, 2, 32'hCAFE_0001, 3);
        check32("mem_written", mem[5'h15], 32'h1234_5678);
        check32("miss_count_2", {24'd0, miss_count}, 32'd2);
        issue(1'b0, 5'h15, 32'd0, 0, 32'h1234_5678, 2);
        issue(1'b0, 5'h0D, 32'd0, 1, 32'hCAFE_0001, 4);
        check32("hit_count_2", {24'd0, hit_count}, 32'd2);
        check32("miss_count_3", {24'd0, miss_count}, 32'd3);

        // cpu_req held high: four hits, one completion each
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.kind = 0; e.rdata = 32'hCAFE_0001; e.lat = 2;
            q.push_back(e);
        end
        @(negedge clk);
        start = ready_seen;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h0D;
        wait_ready(start + 4);
        cpu_req = 1'b0;
        repeat (6) @(negedge clk);
        check32("held_req_completions", ready_seen - start, 32'd4);
        check32("hit_count_6", {24'd0, hit_count}, 32'd6);

        // Reset during MEM_RD of a miss aborts it
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h03;
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check32("abort_cpu_rdata", cpu_rdata, 32'd0);
        check32("abort_miss_count", {24'd0, miss_count}, 32'd0);
        check32("abort_hit_count", {24'd0, hit_count}, 32'd0);
        issue(1'b0, 5'h03, 32'd0, 1, 32'hA000_0003, 4);
        check32("abort_then_miss", {24'd0, miss_count}, 32'd1);

        // 300 reads of one address: hit counter saturates
        pulse_reset();
        issue(1'b0, 5'h0D, 32'd0, 1, 32'hCAFE_0001, 4);
        for (int i = 1; i < 300; i++) issue(1'b0, 5'h0D, 32'd0, 0, 32'hCAFE_0001, 2);
        check32("sat_hit_count", {24'd0, hit_count}, 32'd255);
        check32("sat_miss_count", {24'd0, miss_count}, 32'd1);

        repeat (4) @(negedge clk);
        check32("scoreboard_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
